deinterleaver: RTL
==================

DEINTERLEAVER -- requirements
Module: deinterleaver

Interface
REQ-001 SHALL have parameter ROWS, default 4, meaning row count of the block matrix.
REQ-002 SHALL have parameter COLS, default 4, meaning column count of the block matrix; block length N = ROWS*COLS.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port valid_i  input  1  a data_i bit is present this cycle.
REQ-006 SHALL have port data_i  input  1  serial interleaved bit.
REQ-007 SHALL have port data_o  output  1  serial deinterleaved bit, registered.
REQ-008 SHALL have port valid_o  output  1  data_o is valid this cycle, registered.
REQ-009 SHALL have port frame_o  output  1  marks the first bit of each output block, registered.

Function
REQ-010 SHALL hold two N-bit banks (ping-pong): one is written while the other is read.
REQ-011 SHALL keep a write counter wcnt (0..N-1), a bank selector wsel, and a primed flag.
REQ-012 On a valid_i=1 cycle: SHALL write data_i to bank[wsel][wcnt]; data_o <= bank[!wsel][(wcnt%COLS)*ROWS + wcnt/COLS].
REQ-013 On a valid_i=1 cycle: SHALL set valid_o <= primed and frame_o <= primed && (wcnt==0).
REQ-014 On a valid_i=1 cycle with wcnt<N-1: SHALL increment wcnt.
REQ-015 On a valid_i=1 cycle with wcnt==N-1: SHALL set wcnt to 0, toggle wsel and set primed to 1.
REQ-016 On a valid_i=0 cycle: SHALL hold wcnt, wsel, primed, both banks and data_o, and SHALL drive valid_o <= 0 and frame_o <= 0 (stall, not flush).
REQ-017 Latency: bit i of block b SHALL appear on data_o during block b+1, one clock after the valid input cycle that reads it.
REQ-018 SHALL emit nothing valid for the first N valid inputs after reset (primed=0).
REQ-019 For ROWS=COLS=4, the read map SHALL equal the 4x4 transpose: out k <- in (k%4)*4 + k/4.

Reset
REQ-020 While rst=1, independent of clk: wcnt=0, wsel=0, primed=0, both banks=0, data_o=0, valid_o=0, frame_o=0.
REQ-021 A reset asserted mid-block SHALL discard the partial block and both stored blocks; after release, the next valid bit SHALL be treated as block position 0.

Configuration
REQ-022 With macro DEINTERLEAVER_SYNC_EN defined, SHALL add port sync_i input 1, meaning the current data_i is block position 0.
REQ-023 With DEINTERLEAVER_SYNC_EN defined, sync_i=1 with valid_i=1 SHALL write data_i at position 0, set wcnt to 1 and toggle wsel if wcnt!=0; primed SHALL be set only if wcnt==N-1 (a short block SHALL NOT prime).
REQ-024 With DEINTERLEAVER_SYNC_EN defined, sync_i SHALL be ignored when valid_i=0.
REQ-025 Without DEINTERLEAVER_SYNC_EN, sync_i SHALL be absent and alignment SHALL come from reset only.

Verification
REQ-026 Reset, then 16 valid zeros except in[1]=1, then 16 valid zeros -> valid_o=0 during the first 16 valid cycles; during the next 16, valid_o=1 and data_o=1 only at output position 4; frame_o=1 at output position 0.
REQ-027 Interleaver output of block 0x0001..0xFFFF patterns round-trips, e.g. original 0xA5C3 row-wise -> deinterleaved output bits equal 0xA5C3 in order, one block delayed.
REQ-028 valid_i low for 3 cycles at wcnt=7 -> valid_o=0 and data_o held for those 3 cycles; the output sequence resumes unchanged at position 7.
REQ-029 rst pulse between clock edges at wcnt=9 -> all outputs 0 immediately; the next 16 valid inputs produce valid_o=0.
REQ-030 With DEINTERLEAVER_SYNC_EN, sync_i=1 at wcnt=5 -> wcnt becomes 1, wsel toggles, primed unchanged if previously 0; the following full block deinterleaves correctly.

Source files
------------

// File: rtl/deinterleaver.sv
// Ping-pong block deinterleaver: writes serial bits row-wise into one bank while reading the other in transposed order.
// Optional block-sync input enabled by defining DEINTERLEAVER_SYNC_EN.
module deinterleaver #(
  parameter int ROWS = 4,
  parameter int COLS = 4
) (
  input  logic clk,
  input  logic rst,
`ifdef DEINTERLEAVER_SYNC_EN
  input  logic sync_i,
`endif
  input  logic valid_i,
  input  logic data_i,
  output logic data_o,
  output logic valid_o,
  output logic frame_o
);

  localparam int N  = ROWS * COLS;
  localparam int AW = (N > 1) ? $clog2(N) : 1;

  logic [AW-1:0]         wcnt_q, wcnt_d;
  logic                  wsel_q, wsel_d;
  logic                  primed_q, primed_d;
  logic [1:0][N-1:0]     bank_q, bank_d;
  logic                  data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  frame_q, frame_d;
  logic [AW-1:0]         pos;
  logic                  wsel_eff;

  // Position p of the output block comes from input (p % COLS) * ROWS + p / COLS.
  function automatic logic [AW-1:0] rd_addr(input logic [AW-1:0] p);
    int pi;
    pi = int'(p);
    return AW'((pi % COLS) * ROWS + pi / COLS);
  endfunction

  always_comb begin
    wcnt_d   = wcnt_q;
    wsel_d   = wsel_q;
    primed_d = primed_q;
    bank_d   = bank_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    frame_d  = 1'b0;
    pos      = wcnt_q;
    wsel_eff = wsel_q;
    if (valid_i) begin
`ifdef DEINTERLEAVER_SYNC_EN
      // A sync mid-block abandons the partial block and starts the other bank.
      if (sync_i) begin
        pos = '0;
        if (wcnt_q != '0) wsel_eff = ~wsel_q;
      end
`endif
      bank_d[wsel_eff][pos] = data_i;
      data_d  = bank_q[~wsel_eff][rd_addr(pos)];
      valid_d = primed_q;
      frame_d = primed_q && (pos == '0);
`ifdef DEINTERLEAVER_SYNC_EN
      if (sync_i) begin
        wcnt_d = AW'(1);
        wsel_d = wsel_eff;
        if (wcnt_q == AW'(N - 1)) primed_d = 1'b1;
      end else
`endif
      if (wcnt_q == AW'(N - 1)) begin
        wcnt_d   = '0;
        wsel_d   = ~wsel_q;
        primed_d = 1'b1;
      end else begin
        wcnt_d = wcnt_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt_q   <= '0;
      wsel_q   <= 1'b0;
      primed_q <= 1'b0;
      bank_q   <= '0;
      data_q   <= 1'b0;
      valid_q  <= 1'b0;
      frame_q  <= 1'b0;
    end else begin
      wcnt_q   <= wcnt_d;
      wsel_q   <= wsel_d;
      primed_q <= primed_d;
      bank_q   <= bank_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      frame_q  <= frame_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign frame_o = frame_q;

endmodule
